noc_credit_tracker: RTL and testbench
=====================================

Name: noc_credit_tracker

Overview:
Per-output-port credit counter bank for the 5-port NoC router. Tracks free buffer slots in each downstream neighbour's input FIFO and drives the credit_en_{north,south,east,west,local} inputs of the flow control unit. A counter decrements when a flit leaves on that port and increments when the neighbour returns a credit. It sits directly upstream of the flow control unit and downstream of the link credit-return wires.

Parameters:
BUF_DEPTH, 4, downstream input FIFO depth in flits; reset value of every counter.
CW, $clog2(BUF_DEPTH+1), counter width. Derived; not overridden.

Ports:
clk  input  1  router clock
rst_n  input  1  asynchronous active-low reset
flit_sent_north  input  1  flit launched on north output this cycle
flit_sent_south  input  1  same, south
flit_sent_east  input  1  same, east
flit_sent_west  input  1  same, west
flit_sent_local  input  1  same, local
credit_ret_north  input  1  one-cycle pulse; north neighbour freed one slot
credit_ret_south  input  1  same, south
credit_ret_east  input  1  same, east
credit_ret_west  input  1  same, west
credit_ret_local  input  1  same, local
credit_en_north  output  1  north has at least one credit
credit_en_south  output  1  same, south
credit_en_east  output  1  same, east
credit_en_west  output  1  same, west
credit_en_local  output  1  same, local
credit_cnt_o  output  5*CW  packed counts: port index p occupies [p*CW +: CW]
ovf_err_o  output  5  sticky per port: credit return while the count is full
udf_err_o  output  5  sticky per port: flit sent while the count is zero

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: every count = BUF_DEPTH; all credit_en = 1; ovf_err_o = 0; udf_err_o = 0. Asserting rst_n mid-operation discards in-flight state immediately, without waiting for a clock edge.
- Port index order: north=0, south=1, east=2, west=3, local=4.
- Ports are fully independent; there is no cross-port interaction.
- Per-port count update on the rising edge:
  - sent=1, ret=0, cnt>0: cnt-1.
  - sent=0, ret=1, cnt<BUF_DEPTH: cnt+1.
  - sent=1, ret=1: cnt unchanged, at any value including 0 and BUF_DEPTH. No error flagged.
  - sent=1, ret=0, cnt==0: cnt holds at 0; udf_err_o[p] sets.
  - sent=0, ret=1, cnt==BUF_DEPTH: cnt holds at BUF_DEPTH; ovf_err_o[p] sets.
- Error flags are sticky until reset.
- credit_en_p = (cnt_p != 0), decoded from the registered count. Glitch-free, with no combinational path from any input.
- Latency: a send in cycle N lowers credit_en in cycle N+1 when the count reaches 0. A return in cycle N raises credit_en in cycle N+1.
- The upstream flow control unit must not grant a port whose credit_en is 0. Underflow therefore indicates a protocol violation; it is never normal operation.
- Counter arithmetic is unsigned, CW bits. Saturation is explicit, so there is no wrap-around.

Decomposition:
- Shared package noc_pkg:
  - port index constants PORT_NORTH..PORT_LOCAL (0..4);
  - NUM_PORTS = 5;
  - 3-bit port-address encoding shared with the flow control unit's request address fields.
- One sub-module, credit_cnt_port: a single counter with saturation and sticky error logic, instantiated NUM_PORTS times via generate.
- The top level only maps the named per-direction ports onto index-ordered vectors.

Test Plan:
1. Reset release -> every credit_cnt_o field = 4; all credit_en = 1; ovf_err_o = 0; udf_err_o = 0.
2. flit_sent_north pulsed 4 consecutive cycles -> north count 3,2,1,0; credit_en_north = 0 in the cycle after the 4th send; other ports stay at 4.
3. North at 0, then credit_ret_north one pulse -> count 1 and credit_en_north = 1 next cycle; udf_err_o and ovf_err_o stay 0.
4. East at 2, flit_sent_east and credit_ret_east together for 3 cycles -> count stays 2; no error flags. Repeat at count 0 and count 4 -> unchanged, no flags.
5. Local at 4, credit_ret_local pulsed -> count stays 4; ovf_err_o[4] = 1 and stays 1 afterwards. West at 0, flit_sent_west pulsed -> count stays 0; udf_err_o[3] = 1.
6. rst_n asserted between clock edges with south at 1 and error flags set -> south count 4, credit_en_south = 1, all error flags 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indexing and the 3-bit port address
// encoding also used by the flow control unit's request address fields.
package noc_pkg;

    localparam int unsigned NUM_PORTS  = 5;

    localparam int unsigned PORT_NORTH = 0;
    localparam int unsigned PORT_SOUTH = 1;
    localparam int unsigned PORT_EAST  = 2;
    localparam int unsigned PORT_WEST  = 3;
    localparam int unsigned PORT_LOCAL = 4;

    typedef enum logic [2:0] {
        ADDR_NORTH = 3'd0,
        ADDR_SOUTH = 3'd1,
        ADDR_EAST  = 3'd2,
        ADDR_WEST  = 3'd3,
        ADDR_LOCAL = 3'd4
    } port_addr_t;

    function automatic port_addr_t port_addr(input int unsigned idx);
        return port_addr_t'(idx[2:0]);
    endfunction

endpackage

// File: rtl/credit_cnt_port.sv
// Single-port credit counter: saturating up/down count of free downstream
// FIFO slots with sticky overflow/underflow flags.
module credit_cnt_port #(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flit_sent,
    input  logic          i_credit_ret,
    output logic [CW-1:0] o_cnt,
    output logic          o_credit_en,
    output logic          o_ovf_err,
    output logic          o_udf_err
);

    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    logic [CW-1:0] r_cnt;
    logic          r_ovf_err;
    logic          r_udf_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= FULL;
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            // Simultaneous send and return cancel out at any count.
            case ({i_flit_sent, i_credit_ret})
                2'b10: begin
                    if (r_cnt == '0) r_udf_err <= 1'b1;
                    else             r_cnt     <= r_cnt - 1'b1;
                end
                2'b01: begin
                    if (r_cnt == FULL) r_ovf_err <= 1'b1;
                    else               r_cnt     <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_cnt       = r_cnt;
    assign o_credit_en = (r_cnt != '0);
    assign o_ovf_err   = r_ovf_err;
    assign o_udf_err   = r_udf_err;

endmodule

// File: rtl/noc_credit_tracker.sv
// Five-port credit counter bank feeding the router's flow control unit;
// maps the named direction ports onto index-ordered counter instances.
module noc_credit_tracker
    import noc_pkg::*;
#(
    parameter  int unsigned BUF_DEPTH = 4,
    localparam int unsigned CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flit_sent_north,
    input  logic                  flit_sent_south,
    input  logic                  flit_sent_east,
    input  logic                  flit_sent_west,
    input  logic                  flit_sent_local,
    input  logic                  credit_ret_north,
    input  logic                  credit_ret_south,
    input  logic                  credit_ret_east,
    input  logic                  credit_ret_west,
    input  logic                  credit_ret_local,
    output logic                  credit_en_north,
    output logic                  credit_en_south,
    output logic                  credit_en_east,
    output logic                  credit_en_west,
    output logic                  credit_en_local,
    output logic [5*CW-1:0]       credit_cnt_o,
    output logic [NUM_PORTS-1:0]  ovf_err_o,
    output logic [NUM_PORTS-1:0]  udf_err_o
);

    logic [NUM_PORTS-1:0] w_sent;
    logic [NUM_PORTS-1:0] w_ret;
    logic [NUM_PORTS-1:0] w_en;

    assign w_sent[PORT_NORTH] = flit_sent_north;
    assign w_sent[PORT_SOUTH] = flit_sent_south;
    assign w_sent[PORT_EAST]  = flit_sent_east;
    assign w_sent[PORT_WEST]  = flit_sent_west;
    assign w_sent[PORT_LOCAL] = flit_sent_local;

    assign w_ret[PORT_NORTH]  = credit_ret_north;
    assign w_ret[PORT_SOUTH]  = credit_ret_south;
    assign w_ret[PORT_EAST]   = credit_ret_east;
    assign w_ret[PORT_WEST]   = credit_ret_west;
    assign w_ret[PORT_LOCAL]  = credit_ret_local;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        credit_cnt_port #(
            .BUF_DEPTH (BUF_DEPTH),
            .CW        (CW)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_flit_sent  (w_sent[p]),
            .i_credit_ret (w_ret[p]),
            .o_cnt        (credit_cnt_o[p*CW +: CW]),
            .o_credit_en  (w_en[p]),
            .o_ovf_err    (ovf_err_o[p]),
            .o_udf_err    (udf_err_o[p])
        );
    end

    assign credit_en_north = w_en[PORT_NORTH];
    assign credit_en_south = w_en[PORT_SOUTH];
    assign credit_en_east  = w_en[PORT_EAST];
    assign credit_en_west  = w_en[PORT_WEST];
    assign credit_en_local = w_en[PORT_LOCAL];

endmodule

// File: tb/tb_noc_credit_tracker.sv
// Directed vector bench for noc_credit_tracker (BUF_DEPTH = 4, CW = 3).
module tb_noc_credit_tracker;

    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] sent = '0;   // {local, west, east, south, north}
    logic [4:0] ret  = '0;

    logic en_n, en_s, en_e, en_w, en_l;
    logic [5*CW-1:0] cnt_o;
    logic [4:0] ovf, udf;
    logic [4:0] en;

    assign en = {en_l, en_w, en_e, en_s, en_n};

    always #5 clk = ~clk;

    noc_credit_tracker #(.BUF_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flit_sent_north  (sent[0]),
        .flit_sent_south  (sent[1]),
        .flit_sent_east   (sent[2]),
        .flit_sent_west   (sent[3]),
        .flit_sent_local  (sent[4]),
        .credit_ret_north (ret[0]),
        .credit_ret_south (ret[1]),
        .credit_ret_east  (ret[2]),
        .credit_ret_west  (ret[3]),
        .credit_ret_local (ret[4]),
        .credit_en_north  (en_n),
        .credit_en_south  (en_s),
        .credit_en_east   (en_e),
        .credit_en_west   (en_w),
        .credit_en_local  (en_l),
        .credit_cnt_o     (cnt_o),
        .ovf_err_o        (ovf),
        .udf_err_o        (udf)
    );

    typedef struct {
        logic [4:0] sent;
        logic [4:0] ret;
        int         n, s, e, w, l;
        logic [4:0] en;
        logic [4:0] ovf;
        logic [4:0] udf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [14:0] pack(input int n, s, e, w, l);
        return {3'(l), 3'(w), 3'(e), 3'(s), 3'(n)};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [14:0] c, input logic [4:0] e,
                             input logic [4:0] o, input logic [4:0] u);
        check({tag, " cnt"}, 15'(cnt_o), c);
        check({tag, " en"},  15'(en),    15'(e));
        check({tag, " ovf"}, 15'(ovf),   15'(o));
        check({tag, " udf"}, 15'(udf),   15'(u));
    endtask

    task automatic add(input logic [4:0] s_i, input logic [4:0] r_i,
                       input int n, s, e, w, l,
                       input logic [4:0] en_i, input logic [4:0] o_i, input logic [4:0] u_i);
        vec_t v;
        v.sent = s_i; v.ret = r_i;
        v.n = n; v.s = s; v.e = e; v.w = w; v.l = l;
        v.en = en_i; v.ovf = o_i; v.udf = u_i;
        vecs.push_back(v);
    endtask

    initial begin
        // North drains to 0, then one return
        add(5'b00001, 5'b00000, 3,4,4,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 2,4,4,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 1,4,4,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00001, 5'b00000, 0,4,4,4,4, 5'b11110, 5'b00000, 5'b00000);
        add(5'b00000, 5'b00001, 1,4,4,4,4, 5'b11111, 5'b00000, 5'b00000);
        // East to 2, then simultaneous send+return holds
        add(5'b00100, 5'b00000, 1,4,3,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00000, 1,4,2,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00100, 1,4,2,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00100, 1,4,2,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00100, 1,4,2,4,4, 5'b11111, 5'b00000, 5'b00000);
        // East to 0, simultaneous at 0, back to 4, simultaneous at 4
        add(5'b00100, 5'b00000, 1,4,1,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00000, 1,4,0,4,4, 5'b11011, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00100, 1,4,0,4,4, 5'b11011, 5'b00000, 5'b00000);
        add(5'b00000, 5'b00100, 1,4,1,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00000, 5'b00100, 1,4,2,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00000, 5'b00100, 1,4,3,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00000, 5'b00100, 1,4,4,4,4, 5'b11111, 5'b00000, 5'b00000);
        add(5'b00100, 5'b00100, 1,4,4,4,4, 5'b11111, 5'b00000, 5'b00000);
        // Local overflow, sticky
        add(5'b00000, 5'b10000, 1,4,4,4,4, 5'b11111, 5'b10000, 5'b00000);
        add(5'b00000, 5'b00000, 1,4,4,4,4, 5'b11111, 5'b10000, 5'b00000);
        // West drains to 0, then underflow, sticky
        add(5'b01000, 5'b00000, 1,4,4,3,4, 5'b11111, 5'b10000, 5'b00000);
        add(5'b01000, 5'b00000, 1,4,4,2,4, 5'b11111, 5'b10000, 5'b00000);
        add(5'b01000, 5'b00000, 1,4,4,1,4, 5'b11111, 5'b10000, 5'b00000);
        add(5'b01000, 5'b00000, 1,4,4,0,4, 5'b10111, 5'b10000, 5'b00000);
        add(5'b01000, 5'b00000, 1,4,4,0,4, 5'b10111, 5'b10000, 5'b01000);
        add(5'b00000, 5'b00000, 1,4,4,0,4, 5'b10111, 5'b10000, 5'b01000);
        // South to 1 ahead of the async reset
        add(5'b00010, 5'b00000, 1,3,4,0,4, 5'b10111, 5'b10000, 5'b01000);
        add(5'b00010, 5'b00000, 1,2,4,0,4, 5'b10111, 5'b10000, 5'b01000);
        add(5'b00010, 5'b00000, 1,1,4,0,4, 5'b10111, 5'b10000, 5'b01000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("reset", pack(4,4,4,4,4), 5'b11111, 5'b00000, 5'b00000);

        foreach (vecs[i]) begin
            @(negedge clk);
            sent = vecs[i].sent;
            ret  = vecs[i].ret;
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i),
                      pack(vecs[i].n, vecs[i].s, vecs[i].e, vecs[i].w, vecs[i].l),
                      vecs[i].en, vecs[i].ovf, vecs[i].udf);
        end

        // Async reset mid-cycle: must take effect before the next clk edge
        sent = '0;
        ret  = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", pack(4,4,4,4,4), 5'b11111, 5'b00000, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst", pack(4,4,4,4,4), 5'b11111, 5'b00000, 5'b00000);

        // Counters run normally again after reset
        @(negedge clk);
        sent = 5'b00010;
        @(posedge clk); #1;
        check_all("after_rst_send", pack(4,3,4,4,4), 5'b11111, 5'b00000, 5'b00000);
        @(negedge clk);
        sent = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
